// File: rtl/acondicionador_botones.sv
// -----------------------------------------------------------------------------
// acondicionador_botones
//
// Conditions raw pushbuttons for the pet state machine. Each channel is
// synchronised, debounced, and turned into clean events:
//   - pulso: one cycle when a press is accepted
//   - largo: one cycle once a press has been held long enough
//   - nivel: the debounced pressed level
// The channels are identical and do not interact.
//
// Parameters:
//   N_BOTONES     number of channels (bit 0 = Comida, bit 1 = Medicina)
//   CICLOS_REBOTE consecutive stable cycles needed to accept a change (>=1)
//   CICLOS_LARGO  held cycles before largo fires (>=1)
//   ACTIVO_BAJO   1 = raw pin reads 0 when pressed
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high reset
//   boton_raw  in   [N_BOTONES] asynchronous raw button pins
//   pulso      out  [N_BOTONES] one-cycle press pulse
//   largo      out  [N_BOTONES] one-cycle long-press pulse
//   nivel      out  [N_BOTONES] debounced pressed state (1 = pressed)
// -----------------------------------------------------------------------------
module acondicionador_botones #(
  parameter int N_BOTONES     = 2,
  parameter int CICLOS_REBOTE = 16,
  parameter int CICLOS_LARGO  = 256,
  parameter int ACTIVO_BAJO   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_BOTONES-1:0] boton_raw,
  output logic [N_BOTONES-1:0] pulso,
  output logic [N_BOTONES-1:0] largo,
  output logic [N_BOTONES-1:0] nivel
);

  localparam int W_REB = $clog2(CICLOS_REBOTE + 1);
  localparam int W_LAR = $clog2(CICLOS_LARGO + 1);

  // Counter values compared against. The debounce counter never stores
  // CICLOS_REBOTE itself: the level is accepted on the edge where it would.
  localparam logic [W_REB-1:0] REB_ULTIMO = W_REB'(CICLOS_REBOTE - 1);
  localparam logic [W_LAR-1:0] LAR_ULTIMO = W_LAR'(CICLOS_LARGO - 1);
  localparam logic [W_LAR-1:0] LAR_MAX    = W_LAR'(CICLOS_LARGO);

  // Logical pressed state of every raw pin, before synchronisation.
  logic [N_BOTONES-1:0] pulsado;
  assign pulsado = (ACTIVO_BAJO != 0) ? ~boton_raw : boton_raw;

  genvar gi;
  generate
    for (gi = 0; gi < N_BOTONES; gi++) begin : g_canal
      logic             s1_reg;
      logic             s2_reg;
      logic             nivel_reg;
      logic             pulso_reg;
      logic             largo_reg;
      logic [W_REB-1:0] rebote_reg;
      logic [W_LAR-1:0] sostenido_reg;
      logic             acepta;

      // The synchronised input has disagreed with the accepted level for
      // CICLOS_REBOTE consecutive edges, counting this one.
      assign acepta = (s2_reg != nivel_reg) && (rebote_reg == REB_ULTIMO);

      always_ff @(posedge clk) begin
        if (reset) begin
          s1_reg        <= 1'b0;
          s2_reg        <= 1'b0;
          nivel_reg     <= 1'b0;
          pulso_reg     <= 1'b0;
          largo_reg     <= 1'b0;
          rebote_reg    <= '0;
          sostenido_reg <= '0;
        end else begin
          // Two-flop synchroniser.
          s1_reg <= pulsado[gi];
          s2_reg <= s1_reg;

          // Debounce: any cycle of agreement restarts the count, so a short
          // glitch never changes the accepted level.
          if (s2_reg == nivel_reg) begin
            rebote_reg <= '0;
          end else if (acepta) begin
            rebote_reg <= '0;
            nivel_reg  <= s2_reg;
          end else begin
            rebote_reg <= rebote_reg + W_REB'(1);
          end

          // Press pulse lands together with the rising debounced level.
          pulso_reg <= acepta && s2_reg;

          // Hold counter saturates, so largo fires only once per press.
          if (!nivel_reg) begin
            sostenido_reg <= '0;
          end else if (sostenido_reg != LAR_MAX) begin
            sostenido_reg <= sostenido_reg + W_LAR'(1);
          end

          largo_reg <= nivel_reg && (sostenido_reg == LAR_ULTIMO);
        end
      end

      assign pulso[gi] = pulso_reg;
      assign largo[gi] = largo_reg;
      assign nivel[gi] = nivel_reg;
    end
  endgenerate

endmodule

// File: tb/tb_acondicionador_botones.sv
`timescale 1ns/100ps
module tb_acondicionador_botones;

  logic       clk;
  logic       reset;
  logic [1:0] boton_raw;
  logic [1:0] pulso;
  logic [1:0] largo;
  logic [1:0] nivel;

  int n_checks;
  int n_fails;

  acondicionador_botones #(
    .N_BOTONES    (2),
    .CICLOS_REBOTE(4),
    .CICLOS_LARGO (20),
    .ACTIVO_BAJO  (1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .boton_raw(boton_raw),
    .pulso    (pulso),
    .largo    (largo),
    .nivel    (nivel)
  );

  initial clk = 1'b0;
  always #1 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge. After the
  // i-th call following a stimulus change, i rising edges have passed.
  task automatic ciclo();
    @(negedge clk);
  endtask

  task automatic soltar_y_esperar(input int n);
    boton_raw = 2'b11;
    repeat (n) ciclo();
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    boton_raw = 2'b11;
    for (int i = 1; i <= 3; i++) begin
      ciclo();
      n_checks++;
      if ({pulso, largo, nivel} !== 6'b0) begin
        n_fails++;
        $display("FAIL reset_state cycle %0d: pulso=%b largo=%b nivel=%b, required all 0", i, pulso, largo, nivel);
      end
    end
    reset = 1'b0;
    ciclo();
    n_checks++;
    if ({pulso, largo, nivel} !== 6'b0) begin
      n_fails++;
      $display("FAIL reset_release: pulso=%b largo=%b nivel=%b, required all 0", pulso, largo, nivel);
    end
    repeat (4) ciclo();
    $display("test_reset done");
  endtask

  task automatic test_clean_press();
    logic [1:0] exp_p, exp_n;
    boton_raw = 2'b10;
    for (int i = 1; i <= 10; i++) begin
      ciclo();
      exp_p = (i == 6) ? 2'b01 : 2'b00;
      exp_n = (i >= 6) ? 2'b01 : 2'b00;
      n_checks++;
      if (pulso !== exp_p || nivel !== exp_n) begin
        n_fails++;
        $display("FAIL clean_press cycle %0d: pulso=%b nivel=%b, required pulso=%b nivel=%b", i, pulso, nivel, exp_p, exp_n);
      end
    end
    soltar_y_esperar(12);
    $display("test_clean_press done");
  endtask

  task automatic test_bounce();
    logic [1:0] exp_p, exp_n;
    for (int per = 0; per < 10; per++) begin
      boton_raw = (per % 2 == 0) ? 2'b10 : 2'b11;
      repeat (2) begin
        ciclo();
        n_checks++;
        if (pulso !== 2'b00 || nivel !== 2'b00) begin
          n_fails++;
          $display("FAIL bounce_reject period %0d: pulso=%b nivel=%b, required 00 00", per, pulso, nivel);
        end
      end
    end
    boton_raw = 2'b10;
    for (int i = 1; i <= 10; i++) begin
      ciclo();
      exp_p = (i == 6) ? 2'b01 : 2'b00;
      exp_n = (i >= 6) ? 2'b01 : 2'b00;
      n_checks++;
      if (pulso !== exp_p || nivel !== exp_n) begin
        n_fails++;
        $display("FAIL bounce_settle cycle %0d: pulso=%b nivel=%b, required pulso=%b nivel=%b", i, pulso, nivel, exp_p, exp_n);
      end
    end
    // Three-cycle glitch back to released while debounced pressed.
    boton_raw = 2'b11;
    repeat (3) ciclo();
    boton_raw = 2'b10;
    for (int i = 1; i <= 10; i++) begin
      ciclo();
      n_checks++;
      if (nivel !== 2'b01 || pulso !== 2'b00) begin
        n_fails++;
        $display("FAIL glitch_hold cycle %0d: pulso=%b nivel=%b, required pulso=00 nivel=01", i, pulso, nivel);
      end
    end
    soltar_y_esperar(12);
    $display("test_bounce done");
  endtask

  task automatic test_long_press();
    logic [1:0] exp_p, exp_l;
    boton_raw = 2'b01;
    for (int i = 1; i <= 40; i++) begin
      ciclo();
      exp_p = (i == 6)  ? 2'b10 : 2'b00;
      exp_l = (i == 26) ? 2'b10 : 2'b00;
      n_checks++;
      if (pulso !== exp_p || largo !== exp_l) begin
        n_fails++;
        $display("FAIL long_press cycle %0d: pulso=%b largo=%b, required pulso=%b largo=%b", i, pulso, largo, exp_p, exp_l);
      end
    end
    soltar_y_esperar(12);
    // Short press: released after 10 cycles, largo must stay quiet.
    boton_raw = 2'b01;
    for (int i = 1; i <= 30; i++) begin
      if (i == 11) boton_raw = 2'b11;
      ciclo();
      exp_p = (i == 6) ? 2'b10 : 2'b00;
      n_checks++;
      if (pulso !== exp_p || largo !== 2'b00) begin
        n_fails++;
        $display("FAIL short_press cycle %0d: pulso=%b largo=%b, required pulso=%b largo=00", i, pulso, largo, exp_p);
      end
    end
    $display("test_long_press done");
  endtask

  task automatic test_simultaneous();
    logic [1:0] exp_p;
    for (int rep = 0; rep < 2; rep++) begin
      boton_raw = 2'b00;
      for (int i = 1; i <= 10; i++) begin
        ciclo();
        exp_p = (i == 6) ? 2'b11 : 2'b00;
        n_checks++;
        if (pulso !== exp_p) begin
          n_fails++;
          $display("FAIL simultaneous rep %0d cycle %0d: pulso=%b, required %b", rep, i, pulso, exp_p);
        end
      end
      boton_raw = 2'b11;
      for (int i = 1; i <= 10; i++) begin
        ciclo();
        n_checks++;
        if (pulso !== 2'b00) begin
          n_fails++;
          $display("FAIL simultaneous_release rep %0d cycle %0d: pulso=%b, required 00", rep, i, pulso);
        end
      end
    end
    $display("test_simultaneous done");
  endtask

  task automatic test_reset_mid_hold();
    logic [1:0] exp_p, exp_n;
    boton_raw = 2'b10;
    // pulso after cycle 6, hold counter reaches 12 after cycle 18.
    repeat (18) ciclo();
    reset = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      ciclo();
      n_checks++;
      if ({pulso, largo, nivel} !== 6'b0) begin
        n_fails++;
        $display("FAIL reset_mid_hold cycle %0d: pulso=%b largo=%b nivel=%b, required all 0", i, pulso, largo, nivel);
      end
    end
    reset = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      ciclo();
      exp_p = (i == 6) ? 2'b01 : 2'b00;
      exp_n = (i >= 6) ? 2'b01 : 2'b00;
      n_checks++;
      if (pulso !== exp_p || nivel !== exp_n || largo !== 2'b00) begin
        n_fails++;
        $display("FAIL after_reset cycle %0d: pulso=%b largo=%b nivel=%b, required pulso=%b largo=00 nivel=%b", i, pulso, largo, nivel, exp_p, exp_n);
      end
    end
    soltar_y_esperar(12);
    $display("test_reset_mid_hold done");
  endtask

  task automatic test_release();
    logic [1:0] exp_n;
    boton_raw = 2'b10;
    repeat (10) ciclo();
    boton_raw = 2'b11;
    for (int i = 1; i <= 10; i++) begin
      ciclo();
      exp_n = (i < 6) ? 2'b01 : 2'b00;
      n_checks++;
      if (nivel !== exp_n || pulso !== 2'b00 || largo !== 2'b00) begin
        n_fails++;
        $display("FAIL release cycle %0d: pulso=%b largo=%b nivel=%b, required pulso=00 largo=00 nivel=%b", i, pulso, largo, nivel, exp_n);
      end
    end
    $display("test_release done");
  endtask

  initial begin
    n_checks  = 0;
    n_fails   = 0;
    reset     = 1'b1;
    boton_raw = 2'b11;
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_press();
    test_simultaneous();
    test_reset_mid_hold();
    test_release();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
